// File: rtl/conv_pkg.sv
// Shared definitions for the fixed-point convolution MAC family:
// accumulator sizing, Q-format constants and the sequencer state type.
package conv_pkg;

  localparam int Q_FRAC_W = 16;
  localparam int Q_ONE    = 1 << Q_FRAC_W;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  // Wide enough for TAPS full-precision products without overflow.
  function automatic int acc_width(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/q_saturate.sv
// Rescales a wide fixed-point accumulator back to DATA_W bits with
// floor rounding, clipping to the signed range and flagging the clip.
module q_saturate #(
  parameter int ACC_W  = 68,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] data,
  output logic                     sat
);

  logic signed [ACC_W-1:0]      w_shr;
  logic        [ACC_W-DATA_W:0] w_hi;
  logic                         w_ovf;

  assign w_shr = acc >>> FRAC_W;
  // The value fits only if every bit above the result sign bit matches it.
  assign w_hi  = w_shr[ACC_W-1:DATA_W-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

  always_comb begin
    sat  = w_ovf;
    data = w_shr[DATA_W-1:0];
    if (w_ovf) begin
      data = w_shr[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                            : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_mac_seq.sv
// Streaming signed fixed-point dot product of a TAPS-sample window against
// a programmable weight bank, with a saturating valid/ready result port.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int TAPS   = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_we,
  input  logic [$clog2(TAPS)-1:0]    w_addr,
  input  logic signed [DATA_W-1:0]   w_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       out_sat,
  output logic                       busy
);

  localparam int ACC_W = acc_width(DATA_W, TAPS);
  localparam int TAP_W = $clog2(TAPS);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  state_t                    r_state, w_state_next;
  logic                      r_in_ready;
  logic [TAP_W-1:0]          r_tap;
  logic signed [DATA_W-1:0]  r_w [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_out_data;
  logic                      r_out_sat;

  logic                      w_accept;
  logic                      w_last;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]   w_acc_sum;
  logic signed [DATA_W-1:0]  w_sat_data;
  logic                      w_sat;

  assign w_accept  = in_valid && r_in_ready;
  assign w_last    = (r_state == ACC) && (r_tap == LAST_TAP);
  assign w_prod    = in_data * r_w[r_tap];
  // IDLE starts a fresh window, so the old accumulator is ignored there.
  assign w_acc_sum = ((r_state == IDLE) ? '0 : r_acc)
                   + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  q_saturate #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_sat (
    .acc  (w_acc_sum),
    .data (w_sat_data),
    .sat  (w_sat)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ACC;
      ACC:     if (w_accept && w_last) w_state_next = OUT;
      OUT:     if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != OUT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_tap      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_sum;
      r_tap <= w_last ? '0 : r_tap + 1'b1;
      if (w_last) begin
        r_out_data <= w_sat_data;
        r_out_sat  <= w_sat;
      end
    end
  end

  // Weights are only writable between windows; out-of-range indices drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_w[i] <= '0;
    end else if (w_we && (r_state == IDLE) && (int'(w_addr) < TAPS)) begin
      r_w[w_addr] <= w_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == OUT);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq: Q16.16, nine taps, hand-computed results.
module tb_conv_mac_seq;
  import conv_pkg::*;

  typedef logic [31:0] win_t [9];

  logic        clk = 1'b0;
  logic        rst;
  logic        w_we;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  conv_mac_seq #(.DATA_W(32), .FRAC_W(16), .TAPS(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic load_all(input logic [31:0] d);
    for (int i = 0; i < 9; i++) wr(4'(i), d);
  endtask

  // Presents one sample and returns at the negedge after its handshake.
  task automatic send(input logic [31:0] d);
    int cnt = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20) check("send_timeout", 32'(cnt), 32'd0);
    @(negedge clk);
  endtask

  task automatic send_win(input string tag, input win_t s);
    for (int i = 0; i < 9; i++) send(s[i]);
    in_valid = 1'b0;
    check({tag, "_latency_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic recv(input string tag, input logic [31:0] ed, input logic es);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_sat"}, 32'(out_sat), 32'(es));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    $display("[TB] %s: out_data=0x%08h out_sat=%0b", tag, ed, es);
  endtask

  initial begin
    win_t s;
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Weights k.0, samples 1.0 -> 45.0
    for (int k = 1; k <= 9; k++) wr(4'(k - 1), 32'(k * Q_ONE));
    for (int i = 0; i < 9; i++) s[i] = 32'h0001_0000;
    send_win("ramp", s);
    recv("ramp", 32'h002D_0000, 1'b0);

    // Unit weights, samples -1.0 -> -9.0
    load_all(32'h0001_0000);
    for (int i = 0; i < 9; i++) s[i] = 32'hFFFF_0000;
    send_win("neg", s);
    recv("neg", 32'hFFF7_0000, 1'b0);

    // Single -0.5 sample -> -0.5
    for (int i = 0; i < 9; i++) s[i] = 32'h0;
    s[0] = 32'hFFFF_8000;
    send_win("half", s);
    recv("half", 32'hFFFF_8000, 1'b0);

    // Positive and negative saturation
    load_all(32'h0009_0000);
    for (int i = 0; i < 9; i++) s[i] = 32'h7FFF_0000;
    send_win("satp", s);
    recv("satp", 32'h7FFF_FFFF, 1'b1);
    for (int i = 0; i < 9; i++) s[i] = 32'h8001_0000;
    send_win("satn", s);

    // Output back-pressure: result held, input blocked
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", out_data, 32'h8000_0000);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    recv("satn", 32'h8000_0000, 1'b1);

    // Weight write during ACC is dropped
    load_all(32'h0001_0000);
    for (int i = 0; i < 9; i++) s[i] = 32'h0001_0000;
    send(s[0]);
    send(s[1]);
    check("acc_busy", 32'(busy), 32'd1);
    w_we = 1'b1; w_addr = 4'd3; w_data = 32'h0005_0000;
    send(s[2]);
    w_we = 1'b0;
    for (int i = 3; i < 9; i++) send(s[i]);
    in_valid = 1'b0;
    recv("acc_write", 32'h0009_0000, 1'b0);
    send_win("acc_write_after", s);
    recv("acc_write_after", 32'h0009_0000, 1'b0);

    // Out-of-range address is ignored
    wr(4'd12, 32'h0007_0000);
    send_win("addr12", s);
    recv("addr12", 32'h0009_0000, 1'b0);

    // Write coincident with first sample: applied, but sample uses old w[0]
    w_we = 1'b1; w_addr = 4'd0; w_data = 32'h0002_0000;
    send(s[0]);
    w_we = 1'b0;
    for (int i = 1; i < 9; i++) send(s[i]);
    in_valid = 1'b0;
    recv("coinc_old", 32'h0009_0000, 1'b0);
    send_win("coinc_new", s);
    recv("coinc_new", 32'h000A_0000, 1'b0);

    // Reset mid-window
    for (int i = 0; i < 4; i++) send(32'h0003_0000);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", 32'(in_ready), 32'd1);
    send_win("zero_weights", s);
    recv("zero_weights", 32'h0000_0000, 1'b0);
    load_all(32'h0001_0000);
    for (int i = 0; i < 9; i++) s[i] = 32'(i * 32'h0000_8000);
    send_win("reload", s);
    recv("reload", 32'h0012_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
